// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: payload + control behind a valid/ready handshake,
// with flush-to-bubble and an optional two-entry skid buffer that registers o_ready.
module pipe_stage_reg #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = 8,
  parameter int unsigned SKID       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CTRL_WIDTH-1:0] o_ctrl,
  output logic [1:0]            o_count
);

  localparam bit USE_SKID = (SKID != 0);

  // Encoding doubles as the entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic [CTRL_WIDTH-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
  logic                  valid_q, valid_d;
  logic                  ready_q, ready_d;
  logic                  push, pop;

  // Single-entry mode forwards downstream ready; skid mode breaks that path.
  assign o_ready = USE_SKID ? ready_q : (i_ready | ~valid_q);
  assign push    = i_valid & o_ready;
  assign pop     = valid_q & i_ready;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d     = ST_ONE;
          head_data_d = i_data;
          head_ctrl_d = i_ctrl;
        end
      end
      ST_ONE: begin
        if (push && (pop || !USE_SKID)) begin
          head_data_d = i_data;
          head_ctrl_d = i_ctrl;
        end else if (push) begin
          state_d     = ST_TWO;
          skid_data_d = i_data;
          skid_ctrl_d = i_ctrl;
        end else if (pop) begin
          state_d     = ST_EMPTY;
          head_ctrl_d = '0;
        end
      end
      ST_TWO: begin
        if (pop) begin
          state_d     = ST_ONE;
          head_data_d = skid_data_q;
          head_ctrl_d = skid_ctrl_q;
          skid_ctrl_d = '0;
        end
      end
      default: begin
        state_d     = ST_EMPTY;
        head_ctrl_d = '0;
        skid_ctrl_d = '0;
      end
    endcase

    // Flush drops everything held or arriving; the payload bits are left alone.
    if (i_flush) begin
      state_d     = ST_EMPTY;
      head_data_d = head_data_q;
      head_ctrl_d = '0;
      skid_ctrl_d = '0;
    end

    valid_d = (state_d != ST_EMPTY);
    ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = head_data_q;
  assign o_ctrl  = head_ctrl_q;
  assign o_count = 2'(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one single-entry and one skid instance, each checked
// every cycle against a queue model of the stage, plus directed corner cases.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic          clk;
  logic          rst;
  logic          v0, r0, f0, v1, r1, f1;
  logic [DW-1:0] d0, d1;
  logic [CW-1:0] c0, c1;
  logic          o_ready0, o_valid0, o_ready1, o_valid1;
  logic [DW-1:0] o_data0, o_data1;
  logic [CW-1:0] o_ctrl0, o_ctrl1;
  logic [1:0]    o_count0, o_count1;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t q0[$];
  ent_t q1[$];
  bit   rdy1_m   = 1'b1;

  pipe_stage_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .i_valid(v0), .o_ready(o_ready0), .i_data(d0), .i_ctrl(c0),
    .i_flush(f0), .o_valid(o_valid0), .i_ready(r0), .o_data(o_data0), .o_ctrl(o_ctrl0),
    .o_count(o_count0));

  pipe_stage_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .i_valid(v1), .o_ready(o_ready1), .i_data(d1), .i_ctrl(c1),
    .i_flush(f1), .o_valid(o_valid1), .i_ready(r1), .o_data(o_data1), .o_ctrl(o_ctrl1),
    .o_count(o_count1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare both instances against the queue model.
  task automatic check_all();
    check("valid0", 64'(o_valid0), 64'(q0.size() != 0));
    check("count0", 64'(o_count0), 64'(q0.size()));
    check("ready0", 64'(o_ready0), 64'(r0 | (q0.size() == 0)));
    if (q0.size() != 0) begin
      check("data0", 64'(o_data0), 64'(q0[0].d));
      check("ctrl0", 64'(o_ctrl0), 64'(q0[0].c));
    end else begin
      check("bubble0", 64'(o_ctrl0), 64'(0));
    end
    check("valid1", 64'(o_valid1), 64'(q1.size() != 0));
    check("count1", 64'(o_count1), 64'(q1.size()));
    check("ready1", 64'(o_ready1), 64'(rdy1_m));
    if (q1.size() != 0) begin
      check("data1", 64'(o_data1), 64'(q1[0].d));
      check("ctrl1", 64'(o_ctrl1), 64'(q1[0].c));
    end else begin
      check("bubble1", 64'(o_ctrl1), 64'(0));
    end
  endtask

  // One clock: model absorbs this cycle's handshake, then outputs are checked.
  task automatic step();
    bit rdy0;
    rdy0 = r0 | (q0.size() == 0);
    @(posedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
      rdy1_m = 1'b1;
    end else begin
      if (q0.size() != 0 && r0) void'(q0.pop_front());
      if (v0 && rdy0) q0.push_back('{d: d0, c: c0});
      if (f0) q0.delete();
      if (q1.size() != 0 && r1) void'(q1.pop_front());
      if (v1 && rdy1_m) q1.push_back('{d: d1, c: c1});
      if (f1) q1.delete();
      rdy1_m = (q1.size() < 2);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    v0 = 1'b0; r0 = 1'b0; f0 = 1'b0; d0 = '0; c0 = '0;
    v1 = 1'b0; r1 = 1'b0; f1 = 1'b0; d1 = '0; c1 = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check("rst_data0", 64'(o_data0), 64'(0));
    check("rst_data1", 64'(o_data1), 64'(0));
    check("rst_ready1", 64'(o_ready1), 64'(1));
    rst = 1'b0;
    step();

    // Streaming through the single-entry stage.
    r0 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      v0 = 1'b1; d0 = DW'(i); c0 = 8'h01;
      step();
      check("stream_data", 64'(o_data0), 64'(i));
      check("stream_valid", 64'(o_valid0), 64'(1));
    end
    v0 = 1'b0;
    step();
    check("stream_end_valid", 64'(o_valid0), 64'(0));
    check("stream_end_ctrl", 64'(o_ctrl0), 64'(0));

    // Stall fills the skid stage, then drains in order.
    r1 = 1'b0;
    v1 = 1'b1; d1 = 16'h00AA; c1 = 8'h01;
    step();
    d1 = 16'h00BB; c1 = 8'h02;
    step();
    v1 = 1'b0;
    step();
    check("skid_count", 64'(o_count1), 64'(2));
    check("skid_ready", 64'(o_ready1), 64'(0));
    check("skid_hold", 64'(o_data1), 64'h00AA);
    r1 = 1'b1;
    step();
    check("skid_second", 64'(o_data1), 64'h00BB);
    check("skid_count1", 64'(o_count1), 64'(1));
    check("skid_ready_back", 64'(o_ready1), 64'(1));
    step();
    check("skid_drained", 64'(o_valid1), 64'(0));

    // Flush with a simultaneous push while stalled.
    r1 = 1'b0;
    v1 = 1'b1; d1 = 16'h0011; c1 = 8'hFF;
    step();
    d1 = 16'h0022; c1 = 8'h5A; f1 = 1'b1;
    step();
    check("flush_valid", 64'(o_valid1), 64'(0));
    check("flush_ctrl", 64'(o_ctrl1), 64'(0));
    check("flush_count", 64'(o_count1), 64'(0));
    check("flush_data_kept", 64'(o_data1), 64'h0011);
    f1 = 1'b0; v1 = 1'b0; r1 = 1'b1;
    step();
    step();

    // Reset takes priority over flush and push.
    rst = 1'b1;
    v0 = 1'b1; d0 = 16'h0033; c0 = 8'h07; f0 = 1'b1; r0 = 1'b0;
    v1 = 1'b1; d1 = 16'h0033; c1 = 8'h07; f1 = 1'b1; r1 = 1'b0;
    step();
    check("rf_valid0", 64'(o_valid0), 64'(0));
    check("rf_data0", 64'(o_data0), 64'(0));
    check("rf_valid1", 64'(o_valid1), 64'(0));
    check("rf_data1", 64'(o_data1), 64'(0));
    idle_inputs();
    step();

    // Random traffic on both instances.
    for (int n = 0; n < 10000; n++) begin
      rst = ($urandom_range(0, 999) == 0);
      v0 = ($urandom_range(0, 3) != 0); r0 = ($urandom_range(0, 2) != 0);
      f0 = ($urandom_range(0, 31) == 0);
      d0 = DW'($urandom); c0 = CW'($urandom);
      v1 = ($urandom_range(0, 3) != 0); r1 = ($urandom_range(0, 2) != 0);
      f1 = ($urandom_range(0, 31) == 0);
      d1 = DW'($urandom); c1 = CW'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
